// File: rtl/mem_backend_model_if.sv
// Request / write-data / response bundle between the cache arbiter (master)
// and the main-memory model (slave).
interface mem_backend_model_if #(
    parameter int ADDR_BITS = 28,
    parameter int TAG_BITS  = 5,
    parameter int DATA_BITS = 128
);
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_rw;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic [TAG_BITS-1:0]    mem_req_tag;

    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;

    logic                   mem_resp_valid;
    logic [DATA_BITS-1:0]   mem_resp_data;
    logic [TAG_BITS-1:0]    mem_resp_tag;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_tag
    );
endinterface

// File: rtl/mem_backend_model.sv
// Single-outstanding main-memory model: masked line writes, fixed-latency
// tagged read responses. The line array is never reset.
module mem_backend_model #(
    parameter int ADDR_BITS  = 28,
    parameter int TAG_BITS   = 5,
    parameter int DATA_BITS  = 128,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_backend_model_if.slave   mem
);
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int DEPTH     = 1 << DEPTH_LOG2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WDATA = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    logic [1:0]            state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic [DEPTH_LOG2-1:0] idx_reg, idx_next;
    logic [TAG_BITS-1:0]   tag_reg, tag_next;
    logic [TAG_BITS-1:0]   resp_tag_hold_reg;
    logic [DATA_BITS-1:0]  resp_data_hold_reg;
    logic [DATA_BITS-1:0]  rd_data_reg;

    logic [DATA_BITS-1:0]  mem_array [DEPTH];

    logic                  req_fire;
    logic                  data_fire;
    logic                  rd_fire;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;

    // Lines wrap modulo the array depth; the upper address bits are dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem.mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

    assign req_idx   = mem.mem_req_addr[DEPTH_LOG2-1:0];
    assign req_fire  = (state_reg == ST_IDLE)  && mem.mem_req_valid;
    assign data_fire = (state_reg == ST_WDATA) && mem.mem_req_data_valid;

    // The array is sampled exactly on the edge that enters RESP.
    assign rd_fire = (req_fire && !mem.mem_req_rw && (LATENCY == 1)) ||
                     ((state_reg == ST_WAIT) && (cnt_reg == 4'd1));
    assign rd_idx  = (state_reg == ST_IDLE) ? req_idx : idx_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        tag_next   = tag_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req_fire) begin
                    idx_next = req_idx;
                    tag_next = mem.mem_req_tag;
                    if (mem.mem_req_rw) begin
                        state_next = ST_WDATA;
                    end else begin
                        cnt_next   = LAT_LOAD;
                        state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                    end
                end
            end
            ST_WDATA: begin
                if (data_fire) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd1) begin
                    cnt_next   = 4'd0;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= ST_IDLE;
            cnt_reg            <= 4'd0;
            idx_reg            <= '0;
            tag_reg            <= '0;
            resp_tag_hold_reg  <= '0;
            resp_data_hold_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            tag_reg   <= tag_next;
            if (state_reg == ST_RESP) begin
                resp_tag_hold_reg  <= tag_reg;
                resp_data_hold_reg <= rd_data_reg;
            end
        end
    end

    // Byte-enable write and registered read; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (data_fire) begin
            for (int i = 0; i < MASK_BITS; i++) begin
                if (mem.mem_req_data_mask[i]) begin
                    mem_array[idx_reg][i*8 +: 8] <= mem.mem_req_data_bits[i*8 +: 8];
                end
            end
        end
        if (rd_fire) begin
            rd_data_reg <= mem_array[rd_idx];
        end
    end

    assign mem.mem_req_ready      = (state_reg == ST_IDLE);
    assign mem.mem_req_data_ready = (state_reg == ST_WDATA);
    assign mem.mem_resp_valid     = (state_reg == ST_RESP);
    assign mem.mem_resp_data      = (state_reg == ST_RESP) ? rd_data_reg : resp_data_hold_reg;
    assign mem.mem_resp_tag       = (state_reg == ST_RESP) ? tag_reg : resp_tag_hold_reg;

endmodule

// File: tb/tb_mem_backend_model.sv
// Bench for mem_backend_model: table vectors, reset corner sequences and
// randomized traffic checked against a line-array reference model.
module tb_mem_backend_model;
    localparam int ADDR_BITS  = 28;
    localparam int TAG_BITS   = 5;
    localparam int DATA_BITS  = 128;
    localparam int DEPTH_LOG2 = 10;
    localparam int LAT        = 4;

    logic clk;
    logic reset_n;

    mem_backend_model_if #(
        .ADDR_BITS(ADDR_BITS), .TAG_BITS(TAG_BITS), .DATA_BITS(DATA_BITS)
    ) mem_bus ();

    mem_backend_model #(
        .ADDR_BITS(ADDR_BITS), .TAG_BITS(TAG_BITS), .DATA_BITS(DATA_BITS),
        .DEPTH_LOG2(DEPTH_LOG2), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mem(mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] model_mem [1024];

    typedef struct {
        bit           rw;
        logic [27:0]  addr;
        logic [4:0]   tag;
        logic [127:0] data;
        logic [15:0]  mask;
        int           stall;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(input logic [27:0] addr, input logic [127:0] data,
                                        input logic [15:0] mask);
        int idx = int'(addr) % 1024;
        for (int b = 0; b < 16; b++)
            if (mask[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
    endfunction

    task automatic do_write(input logic [27:0] addr, input logic [127:0] data,
                            input logic [15:0] mask, input int stall);
        check("wr_req_ready_idle", 128'(mem_bus.mem_req_ready), 128'd1);
        mem_bus.mem_req_valid      = 1'b1;
        mem_bus.mem_req_rw         = 1'b1;
        mem_bus.mem_req_addr       = addr;
        mem_bus.mem_req_tag        = 5'($urandom);
        mem_bus.mem_req_data_valid = 1'b0;
        tick();
        mem_bus.mem_req_valid = 1'b0;
        mem_bus.mem_req_rw    = 1'($urandom);
        mem_bus.mem_req_addr  = 28'($urandom);
        for (int s = 0; s < stall; s++) begin
            mem_bus.mem_req_data_bits = {4{32'($urandom)}};
            check("wr_stall_data_ready", 128'(mem_bus.mem_req_data_ready), 128'd1);
            check("wr_stall_req_ready", 128'(mem_bus.mem_req_ready), 128'd0);
            tick();
        end
        check("wr_data_ready", 128'(mem_bus.mem_req_data_ready), 128'd1);
        mem_bus.mem_req_data_valid = 1'b1;
        mem_bus.mem_req_data_bits  = data;
        mem_bus.mem_req_data_mask  = mask;
        tick();
        mem_bus.mem_req_data_valid = 1'b0;
        mem_bus.mem_req_data_bits  = {4{32'($urandom)}};
        check("wr_done_req_ready", 128'(mem_bus.mem_req_ready), 128'd1);
        check("wr_done_data_ready", 128'(mem_bus.mem_req_data_ready), 128'd0);
        model_write(addr, data, mask);
        $display("write addr=%h mask=%h data=%h stall=%0d", addr, mask, data, stall);
    endtask

    task automatic do_read(input logic [27:0] addr, input logic [4:0] tag,
                           input logic [127:0] exp);
        check("rd_req_ready_idle", 128'(mem_bus.mem_req_ready), 128'd1);
        mem_bus.mem_req_valid = 1'b1;
        mem_bus.mem_req_rw    = 1'b0;
        mem_bus.mem_req_addr  = addr;
        mem_bus.mem_req_tag   = tag;
        tick();
        mem_bus.mem_req_valid = 1'b0;
        mem_bus.mem_req_addr  = 28'($urandom);
        mem_bus.mem_req_tag   = 5'($urandom);
        for (int k = 1; k <= LAT; k++) begin
            if (k > 1) tick();
            if (k < LAT) begin
                check("rd_gap_resp_valid", 128'(mem_bus.mem_resp_valid), 128'd0);
                check("rd_gap_req_ready", 128'(mem_bus.mem_req_ready), 128'd0);
            end else begin
                check("rd_resp_valid", 128'(mem_bus.mem_resp_valid), 128'd1);
                check("rd_resp_data", mem_bus.mem_resp_data, exp);
                check("rd_resp_tag", 128'(mem_bus.mem_resp_tag), 128'(tag));
            end
        end
        tick();
        check("rd_after_req_ready", 128'(mem_bus.mem_req_ready), 128'd1);
        check("rd_after_resp_valid", 128'(mem_bus.mem_resp_valid), 128'd0);
        check("rd_hold_data", mem_bus.mem_resp_data, exp);
        check("rd_hold_tag", 128'(mem_bus.mem_resp_tag), 128'(tag));
        $display("read  addr=%h tag=%h data=%h", addr, tag, mem_bus.mem_resp_data);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"}, 128'(mem_bus.mem_req_ready), 128'd1);
        check({pfx, "_data_ready"}, 128'(mem_bus.mem_req_data_ready), 128'd0);
        check({pfx, "_resp_valid"}, 128'(mem_bus.mem_resp_valid), 128'd0);
        check({pfx, "_resp_data"}, mem_bus.mem_resp_data, 128'd0);
        check({pfx, "_resp_tag"}, 128'(mem_bus.mem_resp_tag), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] x1;
        logic [127:0] d;
        logic [27:0]  a;
        logic [4:0]   t;

        reset_n                    = 1'b0;
        mem_bus.mem_req_valid      = 1'b0;
        mem_bus.mem_req_rw         = 1'b0;
        mem_bus.mem_req_addr       = '0;
        mem_bus.mem_req_tag        = '0;
        mem_bus.mem_req_data_valid = 1'b0;
        mem_bus.mem_req_data_bits  = '0;
        mem_bus.mem_req_data_mask  = '0;

        vecs[0]  = '{1'b1, 28'h005, 5'h00, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF, 0, 128'h0};
        vecs[1]  = '{1'b0, 28'h005, 5'h1A, 128'h0, 16'h0, 0, 128'h0123456789ABCDEF0123456789ABCDEF};
        vecs[2]  = '{1'b1, 28'h010, 5'h00, {128{1'b1}}, 16'hFFFF, 0, 128'h0};
        vecs[3]  = '{1'b1, 28'h010, 5'h00, 128'h0, 16'h000F, 1, 128'h0};
        vecs[4]  = '{1'b0, 28'h010, 5'h02, 128'h0, 16'h0, 0, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0}};
        vecs[5]  = '{1'b1, 28'h3FF, 5'h00, {4{32'h11111111}}, 16'hFFFF, 0, 128'h0};
        vecs[6]  = '{1'b1, 28'h400, 5'h00, {16{8'hA5}}, 16'hFFFF, 5, 128'h0};
        vecs[7]  = '{1'b0, 28'h000, 5'h03, 128'h0, 16'h0, 0, {16{8'hA5}}};
        vecs[8]  = '{1'b0, 28'h3FF, 5'h04, 128'h0, 16'h0, 0, {4{32'h11111111}}};
        vecs[9]  = '{1'b1, 28'hFFFFC05, 5'h00, {4{32'h22222222}}, 16'hF0F0, 3, 128'h0};
        vecs[10] = '{1'b0, 28'h005, 5'h1F, 128'h0, 16'h0, 0, 128'h22222222_89ABCDEF_22222222_89ABCDEF};
        vecs[11] = '{1'b1, 28'h010, 5'h00, 128'h1234, 16'h0000, 2, 128'h0};
        vecs[12] = '{1'b0, 28'h410, 5'h10, 128'h0, 16'h0, 0, {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0}};

        // Reset held for three cycles; outputs checked on the first cycle after release.
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check_reset_outputs("reset");
        $display("reset released");

        foreach (vecs[i]) begin
            if (vecs[i].rw) do_write(vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].stall);
            else            do_read(vecs[i].addr, vecs[i].tag, vecs[i].exp_data);
        end

        // Reset during WDATA with data presented: the write must be dropped.
        x1 = 128'hDEADBEEF_CAFEF00D_01020304_A0B0C0D0;
        do_write(28'h020, x1, 16'hFFFF, 0);
        mem_bus.mem_req_valid = 1'b1;
        mem_bus.mem_req_rw    = 1'b1;
        mem_bus.mem_req_addr  = 28'h020;
        tick();
        mem_bus.mem_req_valid      = 1'b0;
        check("wdata_rst_data_ready", 128'(mem_bus.mem_req_data_ready), 128'd1);
        reset_n                    = 1'b0;
        mem_bus.mem_req_data_valid = 1'b1;
        mem_bus.mem_req_data_bits  = '0;
        mem_bus.mem_req_data_mask  = 16'hFFFF;
        tick();
        tick();
        mem_bus.mem_req_data_valid = 1'b0;
        reset_n = 1'b1;
        check_reset_outputs("wdata_rst");
        $display("reset during write data phase");
        do_read(28'h020, 5'h09, x1);

        // Reset two cycles after a read handshake: no response may ever appear.
        mem_bus.mem_req_valid = 1'b1;
        mem_bus.mem_req_rw    = 1'b0;
        mem_bus.mem_req_addr  = 28'h020;
        mem_bus.mem_req_tag   = 5'h0B;
        tick();
        mem_bus.mem_req_valid = 1'b0;
        tick();
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("rd_rst_no_resp", 128'(mem_bus.mem_resp_valid), 128'd0);
            tick();
        end
        reset_n = 1'b1;
        check_reset_outputs("rd_rst");
        for (int c = 0; c < 8; c++) begin
            tick();
            check("rd_rst_quiet_resp", 128'(mem_bus.mem_resp_valid), 128'd0);
            check("rd_rst_quiet_ready", 128'(mem_bus.mem_req_ready), 128'd1);
        end
        $display("reset during read wait");
        do_read(28'h020, 5'h0C, x1);

        // Randomized traffic on a small line window, with upper address bits and idle noise.
        for (int i = 0; i < 16; i++) begin
            do_write(28'(i), {4{32'($urandom)}}, 16'hFFFF, $urandom_range(0, 2));
        end
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 2)) begin
                mem_bus.mem_req_data_valid = 1'($urandom);
                mem_bus.mem_req_data_bits  = {4{32'($urandom)}};
                mem_bus.mem_req_data_mask  = 16'($urandom);
                tick();
            end
            mem_bus.mem_req_data_valid = 1'b0;
            a = 28'($urandom);
            a[9:0] = 10'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                d = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
                do_write(a, d, 16'($urandom), $urandom_range(0, 3));
            end else begin
                t = 5'($urandom);
                do_read(a, t, model_mem[int'(a[9:0])]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_backend_model.md
# mem_backend_model

Single-port main-memory model that sits directly downstream of the cache arbiter and services its tagged request stream. It accepts one read or write request at a time, performs masked 128-bit line writes from the separate write-data channel, and returns read data with the request tag after a fixed, parameterised latency. It is the memory endpoint for the cached configuration in simulation and FPGA builds.

## Interface
Parameters:
- `ADDR_BITS`, 28: request address width, in 16-byte line units.
- `TAG_BITS`, 5: request and response tag width.
- `DATA_BITS`, 128: line width. The mask is `DATA_BITS/8` bits wide.
- `DEPTH_LOG2`, 10: log2 of the number of lines in the array (1024).
- `LATENCY`, 4: cycles from read acceptance to response. Legal range 1..15.

Ports:
- `clk`, in, 1: the only clock. All logic is on the rising edge.
- `reset_n`, in, 1: asynchronous assert, active-low reset.
- `mem_req_valid`, in, 1: request present.
- `mem_req_ready`, out, 1: block can accept a request.
- `mem_req_rw`, in, 1: 1 = write, 0 = read.
- `mem_req_addr`, in, `ADDR_BITS`: line address.
- `mem_req_tag`, in, `TAG_BITS`: request tag.
- `mem_req_data_valid`, in, 1: write data present.
- `mem_req_data_ready`, out, 1: block can accept write data.
- `mem_req_data_bits`, in, `DATA_BITS`: write data.
- `mem_req_data_mask`, in, `DATA_BITS/8`: byte enables. Bit i covers data[8i+7:8i].
- `mem_resp_valid`, out, 1: read response present, single-cycle pulse.
- `mem_resp_data`, out, `DATA_BITS`: read data.
- `mem_resp_tag`, out, `TAG_BITS`: tag of the read request being answered.

## Operation
The FSM has four states: IDLE, WDATA, WAIT and RESP. Only one request is outstanding at a time.

- **IDLE**
  - `mem_req_ready` = 1.
  - On `mem_req_valid` & `mem_req_ready`, latch the address and tag.
  - If rw = 1, go to WDATA.
  - If rw = 0, load the latency counter with `LATENCY-1` and go to WAIT. If `LATENCY` = 1, go directly to RESP.
- **WDATA**
  - `mem_req_data_ready` = 1 and `mem_req_ready` = 0.
  - On data handshake, write the byte lanes whose mask bit is 1 and leave the other lanes unchanged. Then go to IDLE.
  - A mask of all zeros is a legal no-op write.
  - Writes never produce a response.
- **WAIT**
  - Decrement the counter each cycle. At 1, go to RESP.
  - The array is read on the transition into RESP, so the data reflects every write completed before that point.
- **RESP**
  - `mem_resp_valid` = 1 for exactly one cycle, with the data and the latched tag. Go to IDLE.
  - There is no back-pressure on the response; the consumer must take it.

Addressing and data rules:
- The index is `addr[DEPTH_LOG2-1:0]`. Upper address bits are ignored, so addresses wrap modulo 1024 lines.
- `mem_req_data_valid` outside WDATA is ignored, and the data is not consumed.
- `mem_resp_data` and `mem_resp_tag` hold their last value when `mem_resp_valid` = 0.

## Timing
Reset values:
- State = IDLE, counter = 0.
- `mem_req_ready` = 1, `mem_req_data_ready` = 0, `mem_resp_valid` = 0.
- `mem_resp_data` = 0, `mem_resp_tag` = 0.
- The array is not reset, and its contents survive `reset_n`.

Reads:
- Request handshake in cycle T gives `mem_resp_valid` in cycle T+`LATENCY`.
- `mem_req_ready` returns in cycle T+`LATENCY`+1.
- Peak read throughput is one per `LATENCY`+1 cycles.

Writes:
- Request handshake in cycle T gives `mem_req_data_ready` from cycle T+1 until the data handshake in cycle D.
- The array is updated at the end of cycle D, and `mem_req_ready` = 1 in cycle D+1.
- Write data that is already valid at T+1 completes in 2 cycles.

Boundary cases:
- A read to the same line issued at D+1 returns the new data.
- Asserting `reset_n` mid-WAIT or mid-RESP drops the read; no response is ever issued for it.
- Asserting `reset_n` mid-WDATA drops the write; the array is unchanged.
- Request inputs are sampled only on handshake. Changes while `mem_req_ready` = 0 have no effect.

## Test plan
- **Reset:** hold `reset_n` = 0 for 3 cycles, then release -> `mem_req_ready` = 1, `mem_req_data_ready` = 0, `mem_resp_valid` = 0 on the first cycle after release.
- **Full write then read:** write addr 0x005 with data 0x0123…CDEF and mask 0xFFFF, then read 0x005 with tag 0x1A.
  - `mem_resp_valid` pulses exactly 4 cycles after the read handshake.
  - data = 0x0123…CDEF, tag = 0x1A.
  - `mem_req_ready` is low on the cycles in between.
- **Partial write:** write all 0xFF with mask 0xFFFF to addr 0x010, then data 0 with mask 0x000F to 0x010, then read 0x010 -> data = 0xFFFF…FFFF_0000_0000.
- **Address wrap:** write 0xA5A5… to addr 0x400, then read addr 0x000 -> returns 0xA5A5…; addr 0x3FF is unaffected.
- **Write-data stall:** hold `mem_req_data_valid` = 0 for 5 cycles after a write request -> `mem_req_ready` = 0 throughout and no array change; the write completes on the first valid cycle.
- **Reset mid-read:** assert `reset_n` = 0 two cycles after a read handshake -> no `mem_resp_valid` ever appears; a following read of the same line returns its pre-reset contents with the new tag.
